// File: rtl/vedic_pkg.sv
// Shared widths, pipeline stage records and the Vedic partial-product helpers.
package vedic_pkg;

    localparam int unsigned OP_W      = 32;
    localparam int unsigned PROD_W    = 64;
    localparam int unsigned ACC_W_DEF = 80;
    localparam int unsigned CNT_W_DEF = 16;

    // Operand register contents (S1).
    typedef struct packed {
        logic              valid;
        logic              last;
        logic [OP_W-1:0]   a;
        logic [OP_W-1:0]   b;
    } s1_t;

    // Product register contents (S2).
    typedef struct packed {
        logic              valid;
        logic              last;
        logic [PROD_W-1:0] prod;
    } s2_t;

    // 8x8 leaf: AND-array partial products summed vertically.
    function automatic logic [15:0] vedic_8x8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc + (16'(a) << i);
        end
        return acc;
    endfunction

    // 16x16 built from four 8x8 blocks (vertical and crosswise terms).
    function automatic logic [31:0] vedic_16x16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] ll, lh, hl, hh;
        ll = vedic_8x8(a[7:0],  b[7:0]);
        lh = vedic_8x8(a[7:0],  b[15:8]);
        hl = vedic_8x8(a[15:8], b[7:0]);
        hh = vedic_8x8(a[15:8], b[15:8]);
        return {16'b0, ll} + ({16'b0, lh} << 8) + ({16'b0, hl} << 8) + {hh, 16'b0};
    endfunction

endpackage

// File: rtl/vedic_32x32.sv
// Combinational 32x32 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier.
module vedic_32x32
    import vedic_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] y
);

    logic [31:0] ll, lh, hl, hh;

    // Four 16x16 sub-products combined with the crosswise middle terms.
    always_comb begin
        ll = vedic_16x16(a[15:0],  b[15:0]);
        lh = vedic_16x16(a[15:0],  b[31:16]);
        hl = vedic_16x16(a[31:16], b[15:0]);
        hh = vedic_16x16(a[31:16], b[31:16]);
        y  = {32'b0, ll} + ({32'b0, lh} << 16) + ({32'b0, hl} << 16) + {hh, 32'b0};
    end

endmodule

// File: rtl/vedic_mac_32.sv
// Three-stage streaming multiply-accumulate: operand reg, product reg,
// accumulate/output. One beat per cycle; a held result stalls the whole pipe.
module vedic_mac_32
    import vedic_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    s1_t               s1_q, s1_d;
    s2_t               s2_q, s2_d;
    logic [PROD_W-1:0] prod;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_acc_q, out_acc_d;
    logic              out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;

    logic              stall;
    logic [ACC_W:0]    sum;
    logic [CNT_W-1:0]  cnt_inc;
    logic              ovf_nxt;

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_ovf   = out_ovf_q;
    assign out_count = out_cnt_q;

    vedic_32x32 u_mul (
        .a (s1_q.a),
        .b (s1_q.b),
        .y (prod)
    );

    // S1/S2 advance together whenever the output stage is not holding.
    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (!stall) begin
            s1_d.valid = in_valid;
            s1_d.last  = in_last;
            s1_d.a     = in_a;
            s1_d.b     = in_b;
            s2_d.valid = s1_q.valid;
            s2_d.last  = s1_q.last;
            s2_d.prod  = prod;
        end
    end

    // Running sum/count/overflow including the current S2 beat.
    always_comb begin
        sum     = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, s2_q.prod};
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        ovf_nxt = ovf_q | sum[ACC_W];
    end

    // S3: fold beats into the running state; a last beat publishes and clears it.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_ovf_d   = out_ovf_q;
        out_cnt_d   = out_cnt_q;
        if (!stall) begin
            // Not stalled means any held result is being taken this cycle,
            // so out_valid simply follows whether a new frame ends here.
            out_valid_d = s2_q.valid & s2_q.last;
            if (s2_q.valid) begin
                if (s2_q.last) begin
                    out_acc_d = sum[ACC_W-1:0];
                    out_ovf_d = ovf_nxt;
                    out_cnt_d = cnt_inc;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                end else begin
                    acc_d     = sum[ACC_W-1:0];
                    cnt_d     = cnt_inc;
                    ovf_d     = ovf_nxt;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_ovf_q   <= out_ovf_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_vedic_mac_32.sv
// Directed bench for vedic_mac_32: default (80-bit) and 64-bit accumulator instances.
module tb_vedic_mac_32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [79:0] out_acc;
    logic        out_ovf;
    logic [15:0] out_count;

    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] out_acc64;
    logic        out_ovf64;
    logic [15:0] out_count64;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [79:0] res_acc[$];
    logic [15:0] res_cnt[$];
    logic        res_ovf[$];
    int          res_cyc[$];
    logic [63:0] res64_acc[$];
    logic [15:0] res64_cnt[$];
    logic        res64_ovf[$];

    vedic_mac_32 u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    vedic_mac_32 #(.ACC_W(64), .CNT_W(16)) u_dut64 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .out_acc   (out_acc64),
        .out_ovf   (out_ovf64),
        .out_count (out_count64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every result handshake at the edge where it happens.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && out_valid && out_ready) begin
            res_acc.push_back(out_acc);
            res_cnt.push_back(out_count);
            res_ovf.push_back(out_ovf);
            res_cyc.push_back(cyc);
        end
        if (!rst && out_valid64 && out_ready) begin
            res64_acc.push_back(out_acc64);
            res64_cnt.push_back(out_count64);
            res64_ovf.push_back(out_ovf64);
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_res(input int n);
        int budget;
        budget = 50;
        while (res_acc.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("wait_results", 96'(res_acc.size()), 96'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] va[5];
        logic [31:0] vb[5];
        logic [79:0] vp[5];

        va[0] = 32'd7;          vb[0] = 32'd9;     vp[0] = 80'd63;
        va[1] = 32'd1000;       vb[1] = 32'd1000;  vp[1] = 80'd1000000;
        va[2] = 32'hFFFF_FFFF;  vb[2] = 32'd1;     vp[2] = 80'd4294967295;
        va[3] = 32'd12345;      vb[3] = 32'd6789;  vp[3] = 80'd83810205;
        va[4] = 32'd65536;      vb[4] = 32'd65536; vp[4] = 80'h1_0000_0000;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        idle(2);

        // Reset state
        chk("rst_out_valid", 96'(out_valid), 96'(0));
        chk("rst_out_acc",   96'(out_acc),   96'(0));
        chk("rst_out_count", 96'(out_count), 96'(0));
        chk("rst_out_ovf",   96'(out_ovf),   96'(0));
        rst = 1'b0;
        idle(1);
        chk("rst_in_ready",  96'(in_ready),  96'(1));

        // Single beat 1*3: result visible after the third edge following the beat cycle.
        base = res_acc.size();
        beat(32'd1, 32'd3, 1'b1);
        chk("single_lat1", 96'(out_valid), 96'(0));
        idle(1);
        chk("single_lat2", 96'(out_valid), 96'(0));
        idle(1);
        chk("single_valid", 96'(out_valid), 96'(1));
        chk("single_acc",   96'(out_acc),   96'(3));
        chk("single_count", 96'(out_count), 96'(1));
        chk("single_ovf",   96'(out_ovf),   96'(0));
        idle(1);
        chk("single_clear", 96'(out_valid), 96'(0));
        chk("single_nres",  96'(res_acc.size()), 96'(base + 1));

        // Three-beat frame
        base = res_acc.size();
        beat(32'd85,  32'd102, 1'b0);
        beat(32'd238, 32'd119, 1'b0);
        beat(32'd255, 32'd85,  1'b1);
        wait_res(base + 1);
        chk("three_acc",   96'(res_acc[base]), 96'(58667));
        chk("three_count", 96'(res_cnt[base]), 96'(3));
        chk("three_ovf",   96'(res_ovf[base]), 96'(0));

        // Backpressure with two single-beat frames
        idle(2);
        base = res_acc.size();
        out_ready = 1'b0;
        beat(32'd204, 32'd221, 1'b1);
        beat(32'd170, 32'd170, 1'b1);
        idle(2);
        chk("bp_in_ready_a", 96'(in_ready),  96'(0));
        chk("bp_out_valid",  96'(out_valid), 96'(1));
        chk("bp_hold_acc_a", 96'(out_acc),   96'(45084));
        idle(3);
        chk("bp_in_ready_b", 96'(in_ready),  96'(0));
        chk("bp_hold_acc_b", 96'(out_acc),   96'(45084));
        chk("bp_no_xfer",    96'(res_acc.size()), 96'(base));
        out_ready = 1'b1;
        wait_res(base + 2);
        idle(3);
        chk("bp_nres",  96'(res_acc.size()), 96'(base + 2));
        chk("bp_res0",  96'(res_acc[base]),     96'(45084));
        chk("bp_res1",  96'(res_acc[base + 1]), 96'(28900));
        chk("bp_ready", 96'(in_ready), 96'(1));

        // Overflow: 2 * 0xFFFFFFFF^2
        base = res_acc.size();
        beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_res(base + 1);
        chk("ovf64_nres",  96'(res64_acc.size()), 96'(res_acc.size()));
        chk("ovf64_acc",   96'(res64_acc[res64_acc.size() - 1]), 96'h0_FFFF_FFFC_0000_0002);
        chk("ovf64_flag",  96'(res64_ovf[res64_ovf.size() - 1]), 96'(1));
        chk("ovf64_count", 96'(res64_cnt[res64_cnt.size() - 1]), 96'(2));
        chk("ovf80_acc",   96'(res_acc[base]), 96'h1_FFFF_FFFC_0000_0002);
        chk("ovf80_flag",  96'(res_ovf[base]), 96'(0));

        // Reset mid-frame discards the partial sum
        idle(2);
        beat(32'd85, 32'd221, 1'b0);
        beat(32'd85, 32'd221, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_valid", 96'(out_valid), 96'(0));
        base = res_acc.size();
        beat(32'd1, 32'd3, 1'b1);
        wait_res(base + 1);
        idle(3);
        chk("mid_rst_nres",  96'(res_acc.size()), 96'(base + 1));
        chk("mid_rst_acc",   96'(res_acc[base]),  96'(3));
        chk("mid_rst_count", 96'(res_cnt[base]),  96'(1));

        // Five back-to-back single-beat frames
        base = res_acc.size();
        for (int i = 0; i < 5; i++) beat(va[i], vb[i], 1'b1);
        wait_res(base + 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("b2b_acc%0d", i),   96'(res_acc[base + i]), 96'(vp[i]));
            chk($sformatf("b2b_count%0d", i), 96'(res_cnt[base + i]), 96'(1));
            chk($sformatf("b2b_cyc%0d", i),   96'(res_cyc[base + i]), 96'(res_cyc[base] + i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
